// File: rtl/icache_responder.sv
// Direct-mapped one-word-per-frame instruction cache on the datapath fetch channel.
// Latency: hits answer in the same cycle; a miss costs one detect cycle plus (wait+1) MISS cycles.
// Backpressure: iwait stalls the MISS state; the latched miss address fills even if the fetch moves on.
module icache_responder #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 2 - IDX_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [31:0]        miss_addr_q, miss_addr_d;
    logic [31:0]        hit_count_q, hit_count_d;

    // Tag and data storage; contents are meaningless until the matching valid bit is set.
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS];

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               fill_en;

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W+1:2];
    assign fill_tag = miss_addr_q[31:IDX_W+2];

    // Lookup is only answered from IDLE; a flush in the same cycle suppresses the hit.
    always_comb begin
        hit = 1'b0;
        if (state_q == IDLE && imemREN && !flush && valid_q[req_idx]
            && tag_q[req_idx] == req_tag) begin
            hit = 1'b1;
        end
    end

    assign ihit      = hit;
    assign imemload  = hit ? data_q[req_idx] : 32'h0;
    assign iREN      = (state_q == MISS);
    assign iaddr     = (state_q == MISS) ? miss_addr_q : 32'h0;
    assign hit_count = hit_count_q;

    // A fill lands only when memory answers, the miss was not flushed and reset is not asserted.
    assign fill_en = (state_q == MISS) && !iwait && !flush && nRST;

    // Next-state for the control registers: flush dominates, then the fill, then new misses.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        hit_count_d = hit_count_q + (hit ? 32'd1 : 32'd0);
        if (flush) begin
            valid_d = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !hit) begin
                        // Low two bits are forced to zero: memory is word addressed.
                        miss_addr_d = imemaddr & 32'hFFFF_FFFC;
                        state_d     = MISS;
                    end
                end
                MISS: begin
                    if (!iwait) begin
                        valid_d[fill_idx] = 1'b1;
                        state_d           = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= 32'h0;
            hit_count_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            hit_count_q <= hit_count_d;
        end
    end

    // Frame write on fill; the indexed frame is overwritten unconditionally.
    always_ff @(posedge CLK) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed scenarios plus randomized traffic.
// Outputs are compared every cycle (at the falling edge) against a cache model held in the bench.
// Memory is modelled as a sparse word store with a hashed default for untouched addresses.
module tb_icache_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;

    icache_responder #(.SETS(16)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .imemREN   (imemREN),
        .imemaddr  (imemaddr),
        .ihit      (ihit),
        .imemload  (imemload),
        .flush     (flush),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iwait     (iwait),
        .iload     (iload),
        .hit_count (hit_count)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Backing memory: explicit entries override a hashed default.
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Cache model: a table of cached words per index plus one outstanding miss.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    bit          m_busy;
    logic [31:0] m_pend;
    logic [31:0] m_hits;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_busy = 1'b0;
        m_pend = 32'h0;
        m_hits = 32'h0;
    endfunction

    // One clock: drive memory data, compare at negedge, advance model at posedge.
    task automatic cycle();
        bit          e_hit;
        logic [31:0] e_load;
        int          ri;
        iload = m_busy ? mem_rd(m_pend) : $urandom;
        @(negedge CLK);
        ri     = int'(imemaddr[5:2]);
        e_hit  = !m_busy && imemREN && !flush && m_valid[ri] && m_tag[ri] == imemaddr[31:6];
        e_load = e_hit ? m_data[ri] : 32'h0;
        check("ihit",      {31'h0, ihit}, {31'h0, e_hit});
        check("imemload",  imemload, e_load);
        check("iREN",      {31'h0, iREN}, {31'h0, m_busy});
        check("iaddr",     iaddr, m_busy ? m_pend : 32'h0);
        check("hit_count", hit_count, m_hits);
        @(posedge CLK);
        if (!nRST) begin
            model_reset();
        end else begin
            if (e_hit) m_hits = m_hits + 32'd1;
            if (flush) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (!iwait) begin
                    m_valid[m_pend[5:2]] = 1'b1;
                    m_tag[m_pend[5:2]]   = m_pend[31:6];
                    m_data[m_pend[5:2]]  = iload;
                    m_busy               = 1'b0;
                end
            end else if (imemREN && !e_hit) begin
                m_busy = 1'b1;
                m_pend = {imemaddr[31:2], 2'b00};
            end
        end
        #1;
    endtask

    // Miss on addr, let memory stall for waits cycles, confirm the follow-up hit and take it.
    task automatic fetch_miss(input logic [31:0] addr, input logic [31:0] data, input int waits);
        mem[addr] = data;
        imemREN   = 1'b1;
        imemaddr  = addr;
        flush     = 1'b0;
        iwait     = 1'b1;
        cycle();
        check("miss_iren",  {31'h0, iREN}, 32'h1);
        check("miss_iaddr", iaddr, addr);
        repeat (waits) begin
            iwait = 1'b1;
            cycle();
        end
        iwait = 1'b0;
        cycle();
        check("fill_hit",  {31'h0, ihit}, 32'h1);
        check("fill_load", imemload, data);
        cycle();
    endtask

    logic [31:0] hc_saved;

    initial begin
        model_reset();
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = 32'h0;
        flush    = 1'b0;
        iwait    = 1'b1;
        iload    = 32'h0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        // Reset state.
        cycle();
        check("rst_ihit", {31'h0, ihit}, 32'h0);
        check("rst_iren", {31'h0, iREN}, 32'h0);
        check("rst_iaddr", iaddr, 32'h0);
        check("rst_hc",   hit_count, 32'h0);
        nRST = 1'b1;

        // Cold miss: two wait cycles, then hit.
        fetch_miss(32'h40, 32'h2008_000A, 2);
        check("cold_hc", hit_count, 32'h1);

        // Conflict eviction on index 0.
        fetch_miss(32'h80, 32'h1111_1111, 0);
        imemaddr = 32'h40;
        iwait    = 1'b1;
        #1;
        check("evict_ihit", {31'h0, ihit}, 32'h0);
        cycle();
        check("evict_iaddr", iaddr, 32'h40);
        iwait = 1'b0;
        cycle();

        // Address change during MISS: fill still targets the latched address.
        mem[32'h104] = 32'hAABB_CCDD;
        imemaddr = 32'h104;
        iwait    = 1'b1;
        cycle();
        imemaddr = 32'h200;
        cycle();
        iwait = 1'b0;
        cycle();
        check("chg_miss", {31'h0, ihit}, 32'h0);
        cycle();
        check("chg_iaddr", iaddr, 32'h200);
        cycle();
        imemaddr = 32'h104;
        #1;
        check("chg_hit",  {31'h0, ihit}, 32'h1);
        check("chg_load", imemload, 32'hAABB_CCDD);
        cycle();

        // Flush in a MISS cycle while memory answers.
        imemaddr = 32'h308;
        iwait    = 1'b0;
        cycle();
        hc_saved = m_hits;
        flush    = 1'b1;
        cycle();
        flush = 1'b0;
        imemREN = 1'b0;
        #1;
        check("flush_iren", {31'h0, iREN}, 32'h0);
        imemREN = 1'b1;
        imemaddr = 32'h104;
        #1;
        check("flush_miss", {31'h0, ihit}, 32'h0);
        check("flush_hc",   hit_count, hc_saved);
        iwait = 1'b1;

        // Reset while a miss is outstanding; memory answers during the reset edge.
        cycle();
        cycle();
        nRST  = 1'b0;
        iwait = 1'b0;
        cycle();
        nRST  = 1'b1;
        iwait = 1'b1;
        #1;
        check("rmid_iren", {31'h0, iREN}, 32'h0);
        check("rmid_ihit", {31'h0, ihit}, 32'h0);
        check("rmid_hc",   hit_count, 32'h0);

        // Back-to-back hits on four cached words.
        for (int k = 0; k < 4; k++) fetch_miss(32'h10 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 1);
        for (int k = 0; k < 4; k++) begin
            imemaddr = 32'h10 + 32'(4 * k);
            #1;
            check("b2b_hit",  {31'h0, ihit}, 32'h1);
            check("b2b_iren", {31'h0, iREN}, 32'h0);
            check("b2b_load", imemload, 32'hC0DE_0000 + 32'(k));
            cycle();
        end
        check("b2b_hc", hit_count, 32'd8);

        // Randomized traffic over a small address pool so hits and conflicts both occur.
        for (int n = 0; n < 3000; n++) begin
            nRST    = ($urandom % 250) != 0;
            flush   = ($urandom % 40) == 0;
            imemREN = ($urandom % 6) != 0;
            iwait   = ($urandom % 3) != 0;
            if (($urandom % 3) == 0)
                imemaddr = {24'h0, 2'($urandom % 4), 4'($urandom), 2'($urandom)};
            if (($urandom % 50) == 0)
                mem[{imemaddr[31:2], 2'b00}] = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
